seven_seg_scan_driver: RTL

SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

---
 rtl/seven_seg_scan_driver_pkg.sv | 77 +++++++
 rtl/seven_seg_encoder.sv | 20 ++
 rtl/seven_seg_scan_driver.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_driver_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_driver_pkg
// Shared definitions for the multiplexed seven-segment driver:
//   - state_e     : conversion FSM states
//   - SEG_0..SEG_F: segment patterns {dp,g,f,e,d,c,b,a}, active-high
//   - SEG_DASH    : pattern shown on every digit when the value does not fit
//   - SEG_BLANK   : pattern for a suppressed leading zero
//   - seg_lookup  : nibble to segment pattern
//   - bcd_add3    : double-dabble digit correction
// -----------------------------------------------------------------------------
package seven_seg_scan_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEX    = 2'd1,
    ST_DABBLE = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  localparam logic [7:0] SEG_0 = 8'h3F;
  localparam logic [7:0] SEG_1 = 8'h06;
  localparam logic [7:0] SEG_2 = 8'h5B;
  localparam logic [7:0] SEG_3 = 8'h4F;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'h6D;
  localparam logic [7:0] SEG_6 = 8'h7D;
  localparam logic [7:0] SEG_7 = 8'h07;
  localparam logic [7:0] SEG_8 = 8'h7F;
  localparam logic [7:0] SEG_9 = 8'h6F;
  localparam logic [7:0] SEG_A = 8'h77;
  localparam logic [7:0] SEG_B = 8'h7C;
  localparam logic [7:0] SEG_C = 8'h39;
  localparam logic [7:0] SEG_D = 8'h5E;
  localparam logic [7:0] SEG_E = 8'h79;
  localparam logic [7:0] SEG_F = 8'h71;

  localparam logic [7:0] SEG_DASH  = 8'h40;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Decimal point is never driven, so bit 7 is always 0 in these patterns.
  function automatic logic [7:0] seg_lookup(input logic [3:0] nibble);
    logic [7:0] seg;
    case (nibble)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      4'hF:    seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // A BCD digit of 5 or more would become >= 10 after the next doubling,
  // so it is pre-corrected by 3 to make the carry land in the next digit.
  function automatic logic [3:0] bcd_add3(input logic [3:0] digit);
    logic [3:0] res;
    if (digit >= 4'd5) begin
      res = digit + 4'd3;
    end else begin
      res = digit;
    end
    return res;
  endfunction

endpackage

// File: rtl/seven_seg_encoder.sv
// -----------------------------------------------------------------------------
// seven_seg_encoder
// Combinational nibble to seven-segment pattern encoder.
// Ports:
//   nibble_i : 4-bit digit value (0-F)
//   seg_o    : {dp,g,f,e,d,c,b,a}, active-high, dp always 0
// -----------------------------------------------------------------------------
module seven_seg_encoder
  import seven_seg_scan_driver_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] seg_o
);

  // Table lookup of the segment pattern.
  always_comb begin
    seg_o = seg_lookup(nibble_i);
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_driver
// Captures a binary value on Load, converts it to hex nibbles (2 busy cycles)
// or to BCD by double-dabble (DATA_W+1 busy cycles), commits the digits to a
// display register and continuously scans that register onto a multiplexed
// seven-segment display.
// Parameters:
//   DATA_W   : width of Value
//   DIGITS   : number of display digits, digit 0 least significant
//   SCAN_DIV : clock cycles each digit stays selected (>= 1)
// Ports:
//   Clock    : rising-edge clock
//   ResetN   : asynchronous active-low reset
//   Value    : number to display
//   Load     : one-cycle capture request, ignored while Busy
//   Mode     : 0 = hexadecimal, 1 = unsigned decimal
//   BlankLZ  : 1 = suppress leading zeros (live input, not captured)
//   Busy     : capture/conversion in progress
//   Segments : {dp,g,f,e,d,c,b,a} for the selected digit, registered
//   DigitSel : one-hot digit enable, registered
// -----------------------------------------------------------------------------
module seven_seg_scan_driver
  import seven_seg_scan_driver_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 4
) (
  input  logic              Clock,
  input  logic              ResetN,
  input  logic [DATA_W-1:0] Value,
  input  logic              Load,
  input  logic              Mode,
  input  logic              BlankLZ,
  output logic              Busy,
  output logic [7:0]        Segments,
  output logic [DIGITS-1:0] DigitSel
);

  // Shift register layout: {BCD digits, binary value}. The binary part
  // shifts into the BCD part one bit per DABBLE cycle.
  localparam int BCD_W = DIGITS * 4;
  localparam int SR_W  = BCD_W + DATA_W;
  localparam int HEX_W = (DATA_W > BCD_W) ? DATA_W : BCD_W;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [DIGITS-1:0] DSEL_RESET = DIGITS'(1);

  // Conversion FSM and datapath registers
  state_e            state_q;
  logic [SR_W-1:0]   sr_q;
  logic              res_ovf_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;

  // Display register
  logic [BCD_W-1:0]  disp_q;
  logic              disp_ovf_q;
  logic [BCD_W-1:0]  disp_d;
  logic              disp_ovf_d;

  // Scan registers
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  div_d;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_d;

  // Output registers
  logic [7:0]        seg_q;
  logic [7:0]        seg_d;
  logic [DIGITS-1:0] dsel_q;
  logic [DIGITS-1:0] dsel_d;

  // Combinational helpers
  logic [SR_W-1:0]   dabble_s;
  logic [SR_W-1:0]   shifted_s;
  logic              carry_out_s;
  logic [HEX_W-1:0]  hex_ext_s;
  logic [HEX_W-1:0]  hex_upper_s;
  logic [BCD_W-1:0]  hex_digits_s;
  logic              hex_ovf_s;
  logic [BCD_W-1:0]  upper_s;
  logic [3:0]        nib_s;
  logic              blank_s;
  logic [7:0]        enc_seg_s;

  // Double-dabble step: correct every BCD digit, then shift left by one.
  always_comb begin
    dabble_s = sr_q;
    for (int i = 0; i < DIGITS; i++) begin
      dabble_s[DATA_W + 4*i +: 4] = bcd_add3(sr_q[DATA_W + 4*i +: 4]);
    end
    shifted_s   = {dabble_s[SR_W-2:0], 1'b0};
    // A 1 leaving the top digit means the value needs more than DIGITS digits.
    carry_out_s = dabble_s[SR_W-1];
  end

  // Hex split: any set bit above the displayable nibbles is an overflow.
  always_comb begin
    hex_ext_s    = HEX_W'(sr_q[DATA_W-1:0]);
    hex_digits_s = hex_ext_s[BCD_W-1:0];
    hex_upper_s  = hex_ext_s >> BCD_W;
    hex_ovf_s    = |hex_upper_s;
  end

  // Conversion FSM: capture, convert, commit.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q   <= ST_IDLE;
      sr_q      <= '0;
      res_ovf_q <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Load) begin
            sr_q      <= {{BCD_W{1'b0}}, Value};
            res_ovf_q <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= Mode ? ST_DABBLE : ST_HEX;
          end
        end
        ST_HEX: begin
          sr_q      <= {hex_digits_s, {DATA_W{1'b0}}};
          res_ovf_q <= hex_ovf_s;
          state_q   <= ST_COMMIT;
        end
        ST_DABBLE: begin
          sr_q      <= shifted_s;
          res_ovf_q <= res_ovf_q | carry_out_s;
          cnt_q     <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_q <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Display next state: only COMMIT loads a new result.
  always_comb begin
    if (state_q == ST_COMMIT) begin
      disp_d     = sr_q[SR_W-1 -: BCD_W];
      disp_ovf_d = res_ovf_q;
    end else begin
      disp_d     = disp_q;
      disp_ovf_d = disp_ovf_q;
    end
  end

  // Display register.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      disp_q     <= '0;
      disp_ovf_q <= 1'b0;
    end else begin
      disp_q     <= disp_d;
      disp_ovf_q <= disp_ovf_d;
    end
  end

  // Scan divider and digit index next state.
  always_comb begin
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = '0;
      if (idx_q == IDX_W'(DIGITS - 1)) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      div_d = div_q + DIV_W'(1);
      idx_d = idx_q;
    end
  end

  // Scan registers, free-running regardless of Load/Busy.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      div_q <= '0;
      idx_q <= '0;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
    end
  end

  // Select the digit to show next; blank it if it and everything above it is zero.
  always_comb begin
    upper_s = disp_d >> {idx_d, 2'b00};
    nib_s   = upper_s[3:0];
    blank_s = BlankLZ & (idx_d != '0) & (upper_s == '0);
  end

  seven_seg_encoder u_encoder (
    .nibble_i (nib_s),
    .seg_o    (enc_seg_s)
  );

  // Segment pattern and one-hot enable for the next selected digit.
  always_comb begin
    if (disp_ovf_d) begin
      seg_d = SEG_DASH;
    end else if (blank_s) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = enc_seg_s;
    end
    dsel_d = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dsel_d[i] = (idx_d == IDX_W'(i));
    end
  end

  // Output registers, computed from next state so they track the scan exactly.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      seg_q  <= SEG_0;
      dsel_q <= DSEL_RESET;
    end else begin
      seg_q  <= seg_d;
      dsel_q <= dsel_d;
    end
  end

  assign Busy     = busy_q;
  assign Segments = seg_q;
  assign DigitSel = dsel_q;

endmodule
